// File: rtl/altera_nios2_qsys_dct_packer.sv
//------------------------------------------------------------------------------
//  Module   : altera_nios2_qsys_dct_packer
//  Purpose  : Packs 2-bit Nios II OCI trace atoms into 15-slot, 30-bit debug
//             trace (DCT) frames. Each frame is presented with a 4-bit atom
//             count on a valid/ready handshake. The datapath has a pack
//             register and an output register. Atoms that arrive while both
//             stages are full are dropped and recorded in a sticky overflow
//             flag.
//  Options  : DCT_DROP_CNT_EN - adds the saturating drop_count output.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module altera_nios2_qsys_dct_packer #(
    parameter int ATOM_W     = 2,
    parameter int SLOTS      = 15
`ifdef DCT_DROP_CNT_EN
    ,
    parameter int DROP_CNT_W = 8
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     atom_valid,
    input  logic [ATOM_W-1:0]        atom_data,
    input  logic                     flush,
    input  logic                     overflow_clr,
    input  logic                     out_ready,
    output logic [ATOM_W*SLOTS-1:0]  dct_buffer,
    output logic [3:0]               dct_count,
    output logic                     frame_valid,
    output logic                     overflow
`ifdef DCT_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]    drop_count
`endif
);

    localparam int c_BUF_W = ATOM_W * SLOTS;
    localparam int c_CNT_W = 4;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(SLOTS);

    // Pack stage
    logic [c_BUF_W-1:0] r_pack_buf;
    logic [c_CNT_W-1:0] r_pack_cnt;
    logic               r_flush_pend;

    // Output stage
    logic [c_BUF_W-1:0] r_dct_buffer;
    logic [c_CNT_W-1:0] r_dct_count;
    logic               r_frame_valid;
    logic               r_overflow;

    // Combinational datapath
    logic               w_full_wait;
    logic               w_slot_free;
    logic               w_accept;
    logic               w_drop;
    logic               w_flush_req;
    logic               w_commit;
    logic               w_load;
    logic [c_BUF_W-1:0] w_pack_buf;
    logic [c_CNT_W-1:0] w_pack_cnt;
    logic [c_BUF_W-1:0] w_next_buf;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic               w_next_pend;

    // A full pack register can only drain into the output register, so a new
    // atom is only taken in that case when the output register is freeing up.
    assign w_full_wait = (r_pack_cnt == c_FULL);
    assign w_slot_free = !r_frame_valid || out_ready;
    assign w_accept    = atom_valid && (!w_full_wait || w_slot_free);
    assign w_drop      = atom_valid && !w_accept;
    assign w_flush_req = flush || r_flush_pend;

    // Candidate frame: pack contents plus this cycle's atom if it still fits
    always_comb begin
        w_pack_buf = r_pack_buf;
        w_pack_cnt = r_pack_cnt;
        if (w_accept && !w_full_wait) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (r_pack_cnt == c_CNT_W'(k)) begin
                    w_pack_buf[k*ATOM_W +: ATOM_W] = atom_data;
                end
            end
            w_pack_cnt = r_pack_cnt + c_CNT_W'(1);
        end
    end

    assign w_commit = (w_pack_cnt == c_FULL) ||
                      (w_flush_req && (w_pack_cnt != '0));
    assign w_load   = w_commit && w_slot_free;

    // Next pack-stage contents: clear on hand-off (keeping an atom that arrived
    // alongside a full waiting frame), otherwise keep accumulating or stall.
    always_comb begin
        w_next_buf  = w_pack_buf;
        w_next_cnt  = w_pack_cnt;
        w_next_pend = r_flush_pend;
        if (w_load) begin
            w_next_pend = 1'b0;
            if (w_full_wait && w_accept) begin
                w_next_buf = {{(c_BUF_W-ATOM_W){1'b0}}, atom_data};
                w_next_cnt = c_CNT_W'(1);
            end else begin
                w_next_buf = '0;
                w_next_cnt = '0;
            end
        end else if (w_commit) begin
            w_next_pend = r_flush_pend || flush;
        end
    end

    // Pack stage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pack_buf   <= '0;
            r_pack_cnt   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_pack_buf   <= w_next_buf;
            r_pack_cnt   <= w_next_cnt;
            r_flush_pend <= w_next_pend;
        end
    end

    // Output register: load on commit, otherwise release once the consumer takes it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dct_buffer  <= '0;
            r_dct_count   <= '0;
            r_frame_valid <= 1'b0;
        end else if (w_load) begin
            r_dct_buffer  <= w_pack_buf;
            r_dct_count   <= w_pack_cnt;
            r_frame_valid <= 1'b1;
        end else if (out_ready) begin
            r_frame_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

`ifdef DCT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_count;

    // Saturating drop counter; a clear coinciding with a drop restarts at one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (overflow_clr) begin
            r_drop_count <= w_drop ? DROP_CNT_W'(1) : '0;
        end else if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + DROP_CNT_W'(1);
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign dct_buffer  = r_dct_buffer;
    assign dct_count   = r_dct_count;
    assign frame_valid = r_frame_valid;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_altera_nios2_qsys_dct_packer.sv
//------------------------------------------------------------------------------
//  Module   : tb_altera_nios2_qsys_dct_packer
//  Purpose  : Self-checking bench for altera_nios2_qsys_dct_packer. Expected
//             frames are queued when atoms are driven and checked when the
//             consumer takes them.
//  Options  : DCT_DROP_CNT_EN - also checks drop_count.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_altera_nios2_qsys_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'b00;
    logic        flush = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frame_valid;
    logic        overflow;
`ifdef DCT_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    altera_nios2_qsys_dct_packer dut (
        .clk          (clk),
        .reset        (reset),
        .atom_valid   (atom_valid),
        .atom_data    (atom_data),
        .flush        (flush),
        .overflow_clr (overflow_clr),
        .out_ready    (out_ready),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .frame_valid  (frame_valid),
        .overflow     (overflow)
`ifdef DCT_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] buf_v;
        logic [3:0]  cnt;
    } frame_t;

    typedef struct {
        int          n;
        logic [1:0]  val;
        logic        fl;
        logic [3:0]  ecnt;
        logic [29:0] ebuf;
    } vec_t;

    frame_t      sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        hold_prev = 1'b0;
    logic [29:0] prev_buf = '0;
    logic [3:0]  prev_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: 15 atoms whose values are (first+k) mod 4
    function automatic logic [29:0] frame_of(input int first);
        logic [29:0] b;
        b = '0;
        for (int k = 0; k < 15; k++) b[2*k +: 2] = 2'((first + k) % 4);
        return b;
    endfunction

    function automatic frame_t mk(input logic [29:0] b, input logic [3:0] c);
        frame_t f;
        f.buf_v = b;
        f.cnt   = c;
        return f;
    endfunction

    task automatic step(input logic v, input logic [1:0] d, input logic f, input logic clr);
        @(posedge clk);
        #1;
        atom_valid   = v;
        atom_data    = d;
        flush        = f;
        overflow_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Consumer side: pop and compare on every handshake, check held frames stay put
    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'd0, frame_valid}, 32'd1);
                check("hold_buf", {2'd0, dct_buffer}, {2'd0, prev_buf});
                check("hold_cnt", {28'd0, dct_count}, {28'd0, prev_cnt});
            end
            if (frame_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: got buf 0x%0h cnt %0d expected no frame", dct_buffer, dct_count);
                end else begin
                    frame_t e;
                    e = sb.pop_front();
                    check("frame_buf", {2'd0, dct_buffer}, {2'd0, e.buf_v});
                    check("frame_cnt", {28'd0, dct_count}, {28'd0, e.cnt});
                end
            end
            hold_prev = frame_valid && !out_ready;
            prev_buf  = dct_buffer;
            prev_cnt  = dct_count;
        end
    end

    task automatic check_drained(input string name);
        check(name, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   vcount;
        vt[0] = '{4,  2'd3, 1'b1, 4'd4,  30'h0000_00FF};
        vt[1] = '{1,  2'd2, 1'b1, 4'd1,  30'h0000_0002};
        vt[2] = '{7,  2'd1, 1'b1, 4'd7,  30'h0000_1555};
        vt[3] = '{3,  2'd2, 1'b1, 4'd3,  30'h0000_002A};
        vt[4] = '{14, 2'd3, 1'b1, 4'd14, 30'h0FFF_FFFF};
        vt[5] = '{15, 2'd1, 1'b0, 4'd15, 30'h1555_5555};

        // Reset values
        #12;
        check("rst_buf", {2'd0, dct_buffer}, 32'd0);
        check("rst_cnt", {28'd0, dct_count}, 32'd0);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
`ifdef DCT_DROP_CNT_EN
        check("rst_drop", {24'd0, drop_count}, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        // Full frame of 0,1,2,3,... and its latency
        sb.push_back(mk(30'h24E4_E4E4, 4'd15));
        for (int i = 0; i < 15; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0);
        @(negedge clk);
        check("lat_before", {31'd0, frame_valid}, 32'd0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_after", {31'd0, frame_valid}, 32'd1);
        idle(3);
        check_drained("t1_drain");

        // Table of single frames, flushed or filled
        for (int v = 0; v < 6; v++) begin
            sb.push_back(mk(vt[v].ebuf, vt[v].ecnt));
            for (int i = 0; i < vt[v].n; i++) step(1'b1, vt[v].val, 1'b0, 1'b0);
            if (vt[v].fl) step(1'b0, 2'b00, 1'b1, 1'b0);
            idle(4);
            check("vec_drain", sb.size(), 32'd0);
        end
        sb.delete();

        // Backpressure: both stages fill, last two atoms dropped
        step(1'b0, 2'b00, 1'b0, 1'b0);
        out_ready = 1'b0;
        sb.push_back(mk(frame_of(0), 4'd15));
        sb.push_back(mk(frame_of(15), 4'd15));
        for (int i = 0; i < 32; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_valid", {31'd0, frame_valid}, 32'd1);
        check("bp_cnt", {28'd0, dct_count}, 32'd15);
        check("bp_ovf", {31'd0, overflow}, 32'd1);
`ifdef DCT_DROP_CNT_EN
        check("bp_drop", {24'd0, drop_count}, 32'd2);
`endif
        step(1'b1, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check("clr_drop_ovf", {31'd0, overflow}, 32'd1);
`ifdef DCT_DROP_CNT_EN
        check("clr_drop_cnt", {24'd0, drop_count}, 32'd1);
`endif
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check("clr_ovf", {31'd0, overflow}, 32'd0);
`ifdef DCT_DROP_CNT_EN
        check("clr_cnt", {24'd0, drop_count}, 32'd0);
`endif
        step(1'b0, 2'b00, 1'b0, 1'b0);
        out_ready = 1'b1;
        idle(5);
        @(negedge clk);
        check("bp_idle", {31'd0, frame_valid}, 32'd0);
        check_drained("bp_drain");

        // Continuous stream, 45 atoms -> 3 frames, no drop
        vcount = 0;
        for (int f = 0; f < 3; f++) sb.push_back(mk(frame_of(f * 15), 4'd15));
        for (int i = 0; i < 45; i++) begin
            step(1'b1, 2'(i % 4), 1'b0, 1'b0);
            @(negedge clk);
            if (frame_valid) vcount++;
        end
        step(1'b0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        if (frame_valid) vcount++;
        check("stream_frames", vcount, 32'd3);
        check("stream_ovf", {31'd0, overflow}, 32'd0);
        idle(3);
        check_drained("stream_drain");

        // Flush while the output register is busy
        out_ready = 1'b0;
        sb.push_back(mk(frame_of(0), 4'd15));
        sb.push_back(mk(30'h0000_0039, 4'd3));
        for (int i = 0; i < 15; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) step(1'b1, 2'(i), 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle(3);
        @(negedge clk);
        check("fb_held_cnt", {28'd0, dct_count}, 32'd15);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        out_ready = 1'b1;
        idle(5);
        check_drained("fb_drain");

        // Flush with nothing packed: no frame
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle(3);
        @(negedge clk);
        check("empty_flush", {31'd0, frame_valid}, 32'd0);
        check_drained("empty_drain");

        // Reset mid-frame, then a fresh frame starts at slot 0
        out_ready = 1'b0;
        for (int i = 0; i < 22; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_buf", {2'd0, dct_buffer}, 32'd0);
        check("mid_rst_cnt", {28'd0, dct_count}, 32'd0);
        check("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        sb.push_back(mk(30'h0000_000F, 4'd2));
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle(4);
        check_drained("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
